pattern_lock_ctrl: RTL and testbench

Sequencer for the serial pattern-lock datapath. It accepts a bit-serial code entry, compares it against a parameterised pattern, and counts failed attempts. After repeated failures it enforces a timed lockout. It owns the lock/unlock decision so downstream actuator logic sees one registered `unlocked` level.

---
 rtl/pattern_lock_ctrl_if.sv | 27 ++
 rtl/pattern_lock_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pattern_lock_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_lock_ctrl_if.sv
// Entry/status bundle between the pattern-lock sequencer and its host.
// The master side drives code bits and lock requests; the slave side reports lock state.
interface pattern_lock_ctrl_if #(
  parameter int MAX_FAIL = 3
) ();
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic          in;
  logic          in_valid;
  logic          lock_req;
  logic          unlocked;
  logic          lockout;
  logic          busy;
  logic [FW-1:0] fail_cnt;
  logic          match_pulse;
  logic          fail_pulse;

  modport master (
    output in, in_valid, lock_req,
    input  unlocked, lockout, busy, fail_cnt, match_pulse, fail_pulse
  );

  modport slave (
    input  in, in_valid, lock_req,
    output unlocked, lockout, busy, fail_cnt, match_pulse, fail_pulse
  );
endinterface

// File: rtl/pattern_lock_ctrl.sv
// Serial pattern-lock sequencer: code entry, failure counting, timed lockout; all outputs registered, 1-cycle decision latency.
// No backpressure: every in_valid is consumed or ignored. Optional auto-relock via PATTERN_LOCK_AUTO_RELOCK_EN.
module pattern_lock_ctrl #(
  parameter int                  CODE_LEN    = 3,
  parameter logic [CODE_LEN-1:0] CODE        = 3'b110,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCKOUT_CYC = 8,
  parameter int                  RELOCK_CYC  = 16
) (
  input  logic               clk,
  input  logic               rst,
  pattern_lock_ctrl_if.slave bus
);

  localparam int SW   = CODE_LEN - 1;
  localparam int BW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_ENTRY    = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_shift;
  logic [BW-1:0] r_bitcnt;
  logic [TW-1:0] r_timer;
  logic [FW-1:0] r_fail_cnt;
  logic          r_unlocked;
  logic          r_lockout;
  logic          r_busy;
  logic          r_match_pulse;
  logic          r_fail_pulse;

  state_t        w_state_nxt;
  logic [SW-1:0] w_shift_nxt;
  logic [BW-1:0] w_bitcnt_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [FW-1:0] w_fail_nxt;
  logic [FW-1:0] w_fail_inc;
  logic          w_match;
  logic          w_fail;
  logic          w_unlocked_nxt;
  logic          w_lockout_nxt;
  logic          w_busy_nxt;
  logic [CODE_LEN-1:0] w_shift_in;

  // Only CODE_LEN-1 bits are stored; the final bit is compared straight off the input.
  assign w_shift_in = {r_shift, bus.in};
  assign w_fail_inc = (r_fail_cnt == FW'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_LOCKED;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_timer       <= '0;
      r_fail_cnt    <= '0;
      r_unlocked    <= 1'b0;
      r_lockout     <= 1'b0;
      r_busy        <= 1'b0;
      r_match_pulse <= 1'b0;
      r_fail_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_timer       <= w_timer_nxt;
      r_fail_cnt    <= w_fail_nxt;
      r_unlocked    <= w_unlocked_nxt;
      r_lockout     <= w_lockout_nxt;
      r_busy        <= w_busy_nxt;
      r_match_pulse <= w_match;
      r_fail_pulse  <= w_fail;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_timer_nxt  = r_timer;
    w_fail_nxt   = r_fail_cnt;
    w_match      = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      S_LOCKED: begin
        if (!bus.lock_req && bus.in_valid) begin
          w_state_nxt  = S_ENTRY;
          w_shift_nxt  = SW'(bus.in);
          w_bitcnt_nxt = BW'(1);
        end
      end
      S_ENTRY: begin
        if (bus.lock_req) begin
          w_state_nxt  = S_LOCKED;
          w_shift_nxt  = '0;
          w_bitcnt_nxt = '0;
        end else if (bus.in_valid) begin
          if (r_bitcnt == BW'(CODE_LEN - 1)) begin
            w_shift_nxt  = '0;
            w_bitcnt_nxt = '0;
            if (w_shift_in == CODE) begin
              w_state_nxt = S_UNLOCKED;
              w_fail_nxt  = '0;
              w_match     = 1'b1;
`ifdef PATTERN_LOCK_AUTO_RELOCK_EN
              w_timer_nxt = TW'(RELOCK_CYC);
`endif
            end else begin
              w_fail     = 1'b1;
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == FW'(MAX_FAIL)) begin
                w_state_nxt = S_LOCKOUT;
                w_timer_nxt = TW'(LOCKOUT_CYC);
              end else begin
                w_state_nxt = S_LOCKED;
              end
            end
          end else begin
            w_shift_nxt  = w_shift_in[SW-1:0];
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      S_UNLOCKED: begin
        if (bus.lock_req) begin
          w_state_nxt = S_LOCKED;
          w_timer_nxt = '0;
        end
`ifdef PATTERN_LOCK_AUTO_RELOCK_EN
        else if (r_timer <= TW'(1)) begin
          w_state_nxt = S_LOCKED;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
`endif
      end
      S_LOCKOUT: begin
        // Leave on the edge where the timer would hit zero, giving exactly LOCKOUT_CYC cycles.
        if (r_timer <= TW'(1)) begin
          w_state_nxt = S_LOCKED;
          w_timer_nxt = '0;
          w_fail_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_LOCKED;
        w_shift_nxt  = '0;
        w_bitcnt_nxt = '0;
        w_timer_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_unlocked_nxt = (w_state_nxt == S_UNLOCKED);
    w_lockout_nxt  = (w_state_nxt == S_LOCKOUT);
    w_busy_nxt     = (w_state_nxt == S_ENTRY);
  end

  assign bus.unlocked    = r_unlocked;
  assign bus.lockout     = r_lockout;
  assign bus.busy        = r_busy;
  assign bus.fail_cnt    = r_fail_cnt;
  assign bus.match_pulse = r_match_pulse;
  assign bus.fail_pulse  = r_fail_pulse;

endmodule

// File: tb/tb_pattern_lock_ctrl.sv
// Directed bench for pattern_lock_ctrl (CODE=110, MAX_FAIL=3, LOCKOUT_CYC=8, RELOCK_CYC=16).
// Observed word: {unlocked, lockout, busy, match_pulse, fail_pulse, fail_cnt[1:0]}.
module tb_pattern_lock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pattern_lock_ctrl_if #(.MAX_FAIL(3)) bus ();

  pattern_lock_ctrl #(
    .CODE_LEN   (3),
    .CODE       (3'b110),
    .MAX_FAIL   (3),
    .LOCKOUT_CYC(8),
    .RELOCK_CYC (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] w_obs;
  assign w_obs = {bus.unlocked, bus.lockout, bus.busy, bus.match_pulse,
                  bus.fail_pulse, bus.fail_cnt};

  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_UNL   = 7'b1000000;
  localparam logic [6:0] E_MATCH = 7'b1001000;

  logic [2:0] lo_pat [0:6];

  task automatic chk(input string tag, input logic [6:0] exp);
    n_vec++;
    assert (w_obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
      end
  endtask

  task automatic drive(input logic b, input logic v, input logic l);
    @(negedge clk);
    bus.in       = b;
    bus.in_valid = v;
    bus.lock_req = l;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.lock_req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic bits3(input logic [2:0] code);
    drive(code[2], 1'b1, 1'b0);
    drive(code[1], 1'b1, 1'b0);
    drive(code[0], 1'b1, 1'b0);
  endtask

  initial begin
    bus.in       = 1'b0;
    bus.in_valid = 1'b0;
    bus.lock_req = 1'b0;
    lo_pat = '{3'b110, 3'b110, 3'b010, 3'b001, 3'b111, 3'b000, 3'b011};

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", E_IDLE);
    @(negedge clk) rst = 1'b1;

    // Correct entry, one bit per cycle.
    drive(1'b1, 1'b1, 1'b0);
    chk("entry_bit1_busy", 7'b0010000);
    drive(1'b1, 1'b1, 1'b0);
    chk("entry_bit2_busy", 7'b0010000);
    drive(1'b0, 1'b1, 1'b0);
    chk("match_unlock", E_MATCH);
    idle();
    chk("match_pulse_one_cycle", E_UNL);
    drive(1'b1, 1'b1, 1'b0);
    chk("unlocked_ignores_in_valid", E_UNL);
    drive(1'b0, 1'b0, 1'b1);
    chk("lock_req_relocks", E_IDLE);

    // Three wrong entries drive lockout.
    bits3(3'b100);
    chk("fail1", 7'b0000101);
    bits3(3'b100);
    chk("fail2", 7'b0000110);
    bits3(3'b100);
    chk("fail3_lockout", 7'b0100111);
    for (int i = 0; i < 7; i++) begin
      idle();
      chk($sformatf("lockout_hold_%0d", i), 7'b0100011);
    end
    idle();
    chk("lockout_end", E_IDLE);
    drive(1'b1, 1'b1, 1'b0);
    chk("entry_right_after_lockout", 7'b0010000);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("unlock_after_lockout", E_MATCH);
    drive(1'b0, 1'b0, 1'b1);
    chk("relock2", E_IDLE);

    // Abort keeps the failure count; lock_req beats in_valid.
    bits3(3'b100);
    chk("fail_before_abort", 7'b0000101);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("partial_busy", 7'b0010001);
    drive(1'b0, 1'b0, 1'b1);
    chk("abort_no_fail", 7'b0000001);
    drive(1'b1, 1'b1, 1'b1);
    chk("locked_lockreq_drops_bit", 7'b0000001);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    chk("entry_lockreq_beats_valid", 7'b0000001);
    bits3(3'b110);
    chk("fresh_entry_unlocks", E_MATCH);
    drive(1'b0, 1'b0, 1'b1);
    chk("relock3", E_IDLE);

    // Lockout ignores entry bits and lock_req.
    bits3(3'b100);
    bits3(3'b100);
    bits3(3'b100);
    chk("lockout2_enter", 7'b0100111);
    for (int i = 0; i < 7; i++) begin
      drive(lo_pat[i][2], lo_pat[i][1], lo_pat[i][0]);
      chk($sformatf("lockout_ignore_%0d", i), 7'b0100011);
    end
    idle();
    chk("lockout2_end", E_IDLE);

    // Async reset during entry.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("pre_reset_busy", 7'b0010000);
    @(negedge clk) rst = 1'b0;
    #1 chk("reset_mid_entry", E_IDLE);
    @(negedge clk) rst = 1'b1;
    bits3(3'b110);
    chk("unlock_after_reset1", E_MATCH);
    drive(1'b0, 1'b0, 1'b1);

    // Async reset during lockout.
    bits3(3'b100);
    bits3(3'b100);
    bits3(3'b100);
    idle();
    idle();
    chk("pre_reset_lockout", 7'b0100011);
    @(negedge clk) rst = 1'b0;
    #1 chk("reset_mid_lockout", E_IDLE);
    @(negedge clk) rst = 1'b1;
    bits3(3'b110);
    chk("unlock_after_reset2", E_MATCH);

`ifdef PATTERN_LOCK_AUTO_RELOCK_EN
    for (int i = 0; i < 15; i++) begin
      idle();
      chk($sformatf("relock_hold_%0d", i), E_UNL);
    end
    idle();
    chk("auto_relock", E_IDLE);
`else
    repeat (100) idle();
    chk("unlocked_persists", E_UNL);
    drive(1'b0, 1'b0, 1'b1);
    chk("final_relock", E_IDLE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
